// File: rtl/cdr_pkg.sv
// Shared types and arithmetic helpers for the CDR proportional-integral loop filter.
// Gain selection maps to shift amounts; the frequency integrator uses a saturating add.
package cdr_pkg;

  typedef logic signed [1:0] vote_t;

  localparam vote_t VOTE_UP   = 2'sb01;
  localparam vote_t VOTE_NONE = 2'sb00;
  localparam vote_t VOTE_DN   = 2'sb11;

  function automatic int p_shift(input logic [1:0] g, input int frac_w);
    return frac_w - int'(g);
  endfunction

  function automatic int i_shift(input logic [1:0] g);
    return 3 - int'(g);
  endfunction

  // Signed +/- 2^sh, or zero for a tied vote.
  function automatic int vote_step(input vote_t v, input int sh);
    int step;
    step = 0;
    if (v == VOTE_UP) begin
      step = 1 << sh;
    end else if (v == VOTE_DN) begin
      step = -(1 << sh);
    end
    return step;
  endfunction

  // Clamps a + b to the signed range of a w-bit word (w <= 31).
  function automatic int sat_add(input int a, input int b, input int w);
    int sum;
    int hi;
    int lo;
    sum = a + b;
    hi  = (1 << (w - 1)) - 1;
    lo  = -(1 << (w - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/cdr_vote_decim.sv
// Collects DECIM early/late decisions into one majority vote.
// The strobe marks the cycle supplying the last sample of a window.
module cdr_vote_decim
  import cdr_pkg::*;
#(
  parameter int DECIM = 8
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en_i,
  input  logic  up_i,
  input  logic  dn_i,
  input  logic  clear_i,
  output vote_t vote_o,
  output logic  strobe_o
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SUM_W = $clog2(DECIM + 1) + 1;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [SUM_W-1:0] dec;
  logic signed [SUM_W-1:0] sum_now;
  logic                    last;

  always_comb begin
    dec = '0;
    if (en_i && up_i && !dn_i) begin
      dec = SUM_W'(1);
    end else if (en_i && dn_i && !up_i) begin
      dec = '1;
    end
    sum_now  = sum_q + dec;
    last     = (cnt_q == CNT_W'(DECIM - 1));
    strobe_o = en_i && !clear_i && last;

    vote_o = VOTE_NONE;
    if (sum_now > 0) begin
      vote_o = VOTE_UP;
    end else if (sum_now < 0) begin
      vote_o = VOTE_DN;
    end

    cnt_d = cnt_q;
    sum_d = sum_q;
    // A freeze throws away the partial window so the next en cycle is sample 1.
    if (clear_i) begin
      cnt_d = '0;
      sum_d = '0;
    end else if (en_i) begin
      if (last) begin
        cnt_d = '0;
        sum_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sum_d = sum_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sum_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/cdr_pi_loop_filter.sv
// Second-order bang-bang CDR loop filter: saturating frequency integrator plus
// wrapping phase accumulator driving the phase interpolator code.
module cdr_pi_loop_filter
  import cdr_pkg::*;
#(
  parameter int PHASE_W = 9,
  parameter int FRAC_W  = 8,
  parameter int FREQ_W  = 16,
  parameter int DECIM   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     up,
  input  logic                     dn,
  input  logic [1:0]               gainsel,
  input  logic                     freeze,
  input  logic                     load,
  input  logic [PHASE_W-1:0]       load_value,
  output logic [PHASE_W-1:0]       phase_shift,
  output logic signed [FREQ_W-1:0] freq_word,
  output logic                     update,
  output logic                     sat
);

  localparam int ACC_W = PHASE_W + FRAC_W;
  localparam logic signed [FREQ_W-1:0] FREQ_MAX = {1'b0, {(FREQ_W-1){1'b1}}};
  localparam logic signed [FREQ_W-1:0] FREQ_MIN = {1'b1, {(FREQ_W-1){1'b0}}};

  vote_t vote;
  logic  strobe;

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic signed [FREQ_W-1:0] freq_q, freq_d;
  logic                    update_q;
  logic                    sat_q, sat_d;
  logic signed [31:0]      p_step, i_step, freq_sum;

  cdr_vote_decim #(
    .DECIM(DECIM)
  ) u_decim (
    .clk     (clk),
    .reset   (reset),
    .en_i    (en),
    .up_i    (up),
    .dn_i    (dn),
    .clear_i (freeze),
    .vote_o  (vote),
    .strobe_o(strobe)
  );

  // The freshly integrated frequency word feeds the phase path in the same update.
  always_comb begin
    i_step   = vote_step(vote, i_shift(gainsel));
    p_step   = vote_step(vote, p_shift(gainsel, FRAC_W));
    freq_sum = sat_add(int'(freq_q), i_step, FREQ_W);

    freq_d = freq_q;
    acc_d  = acc_q;
    if (strobe) begin
      freq_d = FREQ_W'(freq_sum);
      acc_d  = acc_q + ACC_W'(p_step) + ACC_W'(freq_sum);
    end
    if (load) begin
      acc_d = {load_value, {FRAC_W{1'b0}}};
    end
    sat_d = (freq_d == FREQ_MAX) || (freq_d == FREQ_MIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      freq_q   <= '0;
      update_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      freq_q   <= freq_d;
      update_q <= strobe;
      sat_q    <= sat_d;
    end
  end

  assign phase_shift = acc_q[ACC_W-1:FRAC_W];
  assign freq_word   = freq_q;
  assign update      = update_q;
  assign sat         = sat_q;

endmodule
